// File: rtl/sha2_msg_arbiter.sv
// rtl/sha2_msg_arbiter.sv - round-robin whole-message arbiter in front of one shared sha2 engine
//
// Ports:
//   aclk, areset                 clock, async active-high reset
//   s_req_t{data,valid,last,ready}  N_REQ requester streams (req i at [i*DATA_W +: DATA_W])
//   m_eng_t{data,valid,last,ready}  beats toward the sha2 sink
//   s_eng_t{data,valid}          digest pulse from sha2 (no backpressure)
//   m_res_t{data,id,valid,ready} digest result, tid = requester index
//   busy, err_timeout, err_spurious  status; errors are sticky until reset
module sha2_msg_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 512,
  parameter int TO_CYC = 4096
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [N_REQ*DATA_W-1:0] s_req_tdata,
  input  logic [N_REQ-1:0]        s_req_tvalid,
  input  logic [N_REQ-1:0]        s_req_tlast,
  output logic [N_REQ-1:0]        s_req_tready,
  output logic [DATA_W-1:0]       m_eng_tdata,
  output logic                    m_eng_tvalid,
  output logic                    m_eng_tlast,
  input  logic                    m_eng_tready,
  input  logic [255:0]            s_eng_tdata,
  input  logic                    s_eng_tvalid,
  output logic [255:0]            m_res_tdata,
  output logic [7:0]              m_res_tid,
  output logic                    m_res_tvalid,
  input  logic                    m_res_tready,
  output logic                    busy,
  output logic                    err_timeout,
  output logic                    err_spurious
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int WD_W  = $clog2(TO_CYC) + 1;

  typedef enum logic [1:0] {IDLE, STREAM, WAIT_RES, RESP} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  owner;
  logic [IDX_W-1:0]  pick;
  logic [IDX_W-1:0]  cand;
  logic              pick_vld;
  logic [WD_W-1:0]   wdog;
  logic [255:0]      res_data;
  logic [7:0]        res_tid;
  logic              last_hs;
  logic              wdog_exp;

  // Cyclic priority search: walk from the farthest candidate back to rr_ptr so the
  // nearest valid requester at or after rr_ptr is the one left in pick.
  always_comb begin
    pick     = rr_ptr;
    pick_vld = 1'b0;
    cand     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(rr_ptr) + k) % N_REQ);
      if (s_req_tvalid[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  assign last_hs  = (state == STREAM) && m_eng_tvalid && m_eng_tready && m_eng_tlast;
  assign wdog_exp = (wdog == WD_W'(TO_CYC - 1));

  always_comb begin
    state_nxt    = state;
    s_req_tready = '0;
    m_eng_tdata  = '0;
    m_eng_tvalid = 1'b0;
    m_eng_tlast  = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld) state_nxt = STREAM;
      end
      STREAM: begin
        m_eng_tdata         = s_req_tdata[int'(owner)*DATA_W +: DATA_W];
        m_eng_tvalid        = s_req_tvalid[owner];
        m_eng_tlast         = s_req_tlast[owner];
        s_req_tready[owner] = m_eng_tready;
        if (m_eng_tvalid && m_eng_tready && m_eng_tlast) state_nxt = WAIT_RES;
      end
      WAIT_RES: begin
        // a digest arriving on the final watchdog cycle still wins
        if (s_eng_tvalid)  state_nxt = RESP;
        else if (wdog_exp) state_nxt = IDLE;
      end
      RESP: begin
        if (m_res_tready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      wdog         <= '0;
      res_data     <= '0;
      res_tid      <= '0;
      err_timeout  <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && pick_vld) owner <= pick;
      if (last_hs) begin
        rr_ptr <= (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
        wdog   <= '0;
      end
      if (state == WAIT_RES) begin
        wdog <= wdog + 1'b1;
        if (s_eng_tvalid) begin
          res_data <= s_eng_tdata;
          res_tid  <= 8'(owner);
        end else if (wdog_exp) begin
          err_timeout <= 1'b1;
        end
      end
      if (s_eng_tvalid && state != WAIT_RES) err_spurious <= 1'b1;
    end
  end

  assign m_res_tdata  = res_data;
  assign m_res_tid    = res_tid;
  assign m_res_tvalid = (state == RESP);
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_sha2_msg_arbiter.sv
// tb/tb_sha2_msg_arbiter.sv - randomized message traffic against a queue-based reference model
module tb_sha2_msg_arbiter;
  localparam int N    = 4;
  localparam int DW   = 32;
  localparam int TO   = 128;
  localparam int MAXM = 3;
  localparam int MAXB = 4;
  localparam logic [255:0] H0 = 256'h1;

  logic              aclk = 1'b0;
  logic              areset;
  logic [N*DW-1:0]   s_req_tdata;
  logic [N-1:0]      s_req_tvalid, s_req_tlast, s_req_tready;
  logic [DW-1:0]     m_eng_tdata;
  logic              m_eng_tvalid, m_eng_tlast, m_eng_tready;
  logic [255:0]      s_eng_tdata;
  logic              s_eng_tvalid;
  logic [255:0]      m_res_tdata;
  logic [7:0]        m_res_tid;
  logic              m_res_tvalid, m_res_tready;
  logic              busy, err_timeout, err_spurious;

  sha2_msg_arbiter #(.N_REQ(N), .DATA_W(DW), .TO_CYC(TO)) dut (
    .aclk(aclk), .areset(areset),
    .s_req_tdata(s_req_tdata), .s_req_tvalid(s_req_tvalid), .s_req_tlast(s_req_tlast),
    .s_req_tready(s_req_tready),
    .m_eng_tdata(m_eng_tdata), .m_eng_tvalid(m_eng_tvalid), .m_eng_tlast(m_eng_tlast),
    .m_eng_tready(m_eng_tready),
    .s_eng_tdata(s_eng_tdata), .s_eng_tvalid(s_eng_tvalid),
    .m_res_tdata(m_res_tdata), .m_res_tid(m_res_tid), .m_res_tvalid(m_res_tvalid),
    .m_res_tready(m_res_tready),
    .busy(busy), .err_timeout(err_timeout), .err_spurious(err_spurious)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // stand-in for the sha2 engine: any order-sensitive fold of the beats will do
  function automatic logic [255:0] mix(input logic [255:0] h, input logic [DW-1:0] b);
    return {h[254:0], h[255]} ^ {8{b}};
  endfunction

  // source messages
  logic [DW-1:0] beat_d [N][MAXM*MAXB];
  bit            beat_l [N][MAXM*MAXB];
  bit            beat_f [N][MAXM*MAXB];
  int            nbeats [N];
  int            bptr   [N];
  int            nmsg   [N];
  int            mstart [N][MAXM];
  int            mlen   [N][MAXM];

  // expected engine stream, grant order and results
  logic [DW-1:0]  xe_d[$];
  bit             xe_l[$];
  int             xo[$];
  logic [255:0]   xr_d[$];
  int             xr_tid[$];

  // engine / consumer model state
  logic [255:0] eng_h = H0;
  logic [255:0] pend_dig = '0;
  int           eng_cd = -1;
  int           eng_done = 0;
  int           res_cnt = 0;
  int           stall = 0;
  bit           hold = 0;
  logic [255:0] prev_d = '0;
  logic [7:0]   prev_tid = '0;
  int           ow_exp;

  task automatic build_traffic();
    int rem [N];
    int ptr, total, sel, m;
    logic [255:0] h;
    total = 0;
    for (int i = 0; i < N; i++) begin
      nbeats[i] = 0;
      bptr[i]   = 0;
      nmsg[i]   = $urandom_range(1, MAXM);
      for (int mm = 0; mm < nmsg[i]; mm++) begin
        mlen[i][mm]   = (i == 0 && mm == 0) ? 1 : $urandom_range(1, MAXB);
        mstart[i][mm] = nbeats[i];
        for (int b = 0; b < mlen[i][mm]; b++) begin
          beat_d[i][nbeats[i]] = $urandom;
          beat_l[i][nbeats[i]] = (b == mlen[i][mm] - 1);
          beat_f[i][nbeats[i]] = (b == 0);
          nbeats[i]++;
        end
      end
      rem[i] = nmsg[i];
      total += nmsg[i];
    end
    // every pending requester holds its first beat valid, so service order is pure rr
    ptr = 0;
    while (total > 0) begin
      sel = 0;
      for (int k = N - 1; k >= 0; k--) begin
        if (rem[(ptr + k) % N] > 0) sel = (ptr + k) % N;
      end
      m = nmsg[sel] - rem[sel];
      h = H0;
      for (int b = 0; b < mlen[sel][m]; b++) begin
        xe_d.push_back(beat_d[sel][mstart[sel][m] + b]);
        xe_l.push_back(beat_l[sel][mstart[sel][m] + b]);
        h = mix(h, beat_d[sel][mstart[sel][m] + b]);
      end
      xo.push_back(sel);
      xr_d.push_back(h);
      xr_tid.push_back(sel);
      rem[sel]--;
      total--;
      ptr = (sel + 1) % N;
    end
  endtask

  task automatic run_traffic();
    for (int cyc = 0; cyc < 20000 && xr_d.size() > 0; cyc++) begin
      @(negedge aclk);
      for (int i = 0; i < N; i++) begin
        if (bptr[i] < nbeats[i]) begin
          s_req_tdata[i*DW +: DW] = beat_d[i][bptr[i]];
          s_req_tlast[i]          = beat_l[i][bptr[i]];
          s_req_tvalid[i]         = beat_f[i][bptr[i]] ? 1'b1 : ($urandom_range(0, 2) != 0);
        end else begin
          s_req_tdata[i*DW +: DW] = $urandom;
          s_req_tlast[i]          = 1'b0;
          s_req_tvalid[i]         = 1'b0;
        end
      end
      m_eng_tready = ($urandom_range(0, 3) != 0);
      s_eng_tvalid = 1'b0;
      s_eng_tdata  = '0;
      if (eng_cd == 0) begin
        s_eng_tvalid = 1'b1;
        s_eng_tdata  = pend_dig;
        eng_cd       = -1;
      end else if (eng_cd > 0) begin
        eng_cd--;
      end
      m_res_tready = (res_cnt == 1 && stall < 20) ? 1'b0 : ($urandom_range(0, 1) == 1);
      #1;
      if (s_req_tready != '0) begin
        ow_exp = (eng_done < xo.size()) ? xo[eng_done] : 0;
        check("grant_owner", s_req_tready, 1 << ow_exp);
      end
      for (int i = 0; i < N; i++)
        if (s_req_tvalid[i] && s_req_tready[i]) bptr[i]++;
      if (m_eng_tvalid && m_eng_tready) begin
        if (xe_d.size() == 0) begin
          check("eng_extra_beat", xe_d.size(), 1);
        end else begin
          check("eng_data", m_eng_tdata, xe_d[0]);
          check("eng_last", m_eng_tlast, xe_l[0]);
          void'(xe_d.pop_front());
          void'(xe_l.pop_front());
        end
        eng_h = mix(eng_h, m_eng_tdata);
        if (m_eng_tlast) begin
          pend_dig = eng_h;
          eng_h    = H0;
          eng_cd   = (eng_done == 0) ? 70 : $urandom_range(0, 30);
          eng_done++;
        end
      end
      if (hold && !m_res_tvalid) check("res_valid_drop", m_res_tvalid, 1);
      if (m_res_tvalid) begin
        if (hold) begin
          check("res_hold_data", m_res_tdata, prev_d);
          check("res_hold_tid", m_res_tid, prev_tid);
        end
        check("res_no_grant", s_req_tready, 0);
        if (res_cnt == 1) stall++;
        if (m_res_tready) begin
          if (xr_d.size() == 0) begin
            check("res_extra", xr_d.size(), 1);
          end else begin
            check("res_data", m_res_tdata, xr_d[0]);
            check("res_tid", m_res_tid, xr_tid[0]);
            void'(xr_d.pop_front());
            void'(xr_tid.pop_front());
          end
          res_cnt++;
          hold = 0;
        end else begin
          hold     = 1;
          prev_d   = m_res_tdata;
          prev_tid = m_res_tid;
        end
      end else begin
        hold = 0;
      end
    end
  endtask

  task automatic wait_hs(input int i, output bit ok);
    ok = 0;
    for (int k = 0; k < 64; k++) begin
      #1;
      if (s_req_tvalid[i] && s_req_tready[i]) begin
        ok = 1;
        break;
      end
      @(negedge aclk);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tready"}, s_req_tready, 0);
    check({tag, "_eng_tvalid"}, m_eng_tvalid, 0);
    check({tag, "_eng_tlast"}, m_eng_tlast, 0);
    check({tag, "_res_tvalid"}, m_res_tvalid, 0);
    check({tag, "_res_tdata"}, m_res_tdata, 0);
    check({tag, "_res_tid"}, m_res_tid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err_timeout"}, err_timeout, 0);
  endtask

  initial begin
    bit ok;
    bit seen_res;
    int cnt;
    areset       = 1'b1;
    s_req_tdata  = '0;
    s_req_tvalid = '0;
    s_req_tlast  = '0;
    m_eng_tready = 1'b0;
    s_eng_tdata  = '0;
    s_eng_tvalid = 1'b0;
    m_res_tready = 1'b0;
    repeat (3) @(negedge aclk);
    #1;
    check_reset_outputs("rst");
    check("rst_err_spurious", err_spurious, 0);

    // random traffic, every requester pending from the first cycle out of reset
    build_traffic();
    @(negedge aclk);
    areset = 1'b0;
    run_traffic();
    check("rand_results_left", xr_d.size(), 0);
    check("rand_beats_left", xe_d.size(), 0);
    check("rand_err_spurious", err_spurious, 0);
    check("rand_err_timeout", err_timeout, 0);

    // watchdog abort: req1 sends one beat and the engine stays silent
    @(negedge aclk);
    s_req_tvalid = 4'b0010;
    s_req_tlast  = 4'b0010;
    s_req_tdata  = '0;
    s_req_tdata[1*DW +: DW] = 32'hA5A5_0001;
    m_eng_tready = 1'b1;
    m_res_tready = 1'b1;
    s_eng_tvalid = 1'b0;
    wait_hs(1, ok);
    check("t5_hs", ok, 1);
    check("t5_eng_data", m_eng_tdata, 32'hA5A5_0001);
    @(negedge aclk);
    s_req_tvalid = '0;
    s_req_tlast  = '0;
    cnt      = 0;
    seen_res = 0;
    for (int k = 0; k < 3 * TO; k++) begin
      #1;
      if (m_res_tvalid) seen_res = 1;
      if (!busy) break;
      cnt++;
      @(negedge aclk);
    end
    check("t5_wait_cycles", cnt, TO);
    check("t5_err_timeout", err_timeout, 1);
    check("t5_no_result", seen_res, 0);
    check("t5_busy", busy, 0);

    // rr pointer moved past req1: with req0 and req3 both pending, req3 wins
    @(negedge aclk);
    s_req_tvalid = 4'b1001;
    s_req_tlast  = 4'b1001;
    s_req_tdata[0*DW +: DW] = 32'h1111_0000;
    s_req_tdata[3*DW +: DW] = 32'h3333_0003;
    wait_hs(3, ok);
    check("t5_rr_hs", ok, 1);
    check("t5_rr_grant", s_req_tready, 4'b1000);
    check("t5_rr_data", m_eng_tdata, 32'h3333_0003);
    @(negedge aclk);
    s_req_tvalid = 4'b0100;
    s_req_tlast  = 4'b0000;
    s_req_tdata[2*DW +: DW] = 32'h2222_0001;
    s_eng_tvalid = 1'b1;
    s_eng_tdata  = {8{32'hD5D5_0003}};
    @(negedge aclk);
    s_eng_tvalid = 1'b0;
    #1;
    check("t5_res_valid", m_res_tvalid, 1);
    check("t5_res_tid", m_res_tid, 3);
    check("t5_res_data", m_res_tdata, {8{32'hD5D5_0003}});

    // reset in the middle of req2's message, then a stray digest while idle
    wait_hs(2, ok);
    check("t6_hs", ok, 1);
    @(negedge aclk);
    s_req_tdata[2*DW +: DW] = 32'h2222_0002;
    areset = 1'b1;
    #1;
    check_reset_outputs("t6_rst");
    check("t6_rst_err_spurious", err_spurious, 0);
    @(negedge aclk);
    areset       = 1'b0;
    s_req_tvalid = '0;
    @(negedge aclk);
    s_eng_tvalid = 1'b1;
    s_eng_tdata  = {8{32'hBAD0_BAD0}};
    @(negedge aclk);
    s_eng_tvalid = 1'b0;
    #1;
    check("t6_err_spurious", err_spurious, 1);
    check("t6_busy", busy, 0);
    check("t6_res_valid", m_res_tvalid, 0);
    check("t6_res_data", m_res_tdata, 0);
    check("t6_err_timeout", err_timeout, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
